// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
//   state_e   : sequencer FSM states
//   CTRL_*    : bit positions inside the ictrl/octrl control field
//   stage_w() : width of the stage counter for a given log2 transform length
//   tw_index(): twiddle ROM index for butterfly j of stage s
package fft_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StDrain,
    StUpdate,
    StDone
  } state_e;

  localparam int unsigned CTRL_LAST_STAGE = 0;
  localparam int unsigned CTRL_LAST_FFT   = 1;

  function automatic int unsigned stage_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (j mod 2^s) << (n-1-s): stage 0 only uses W^0, the last stage walks every index.
  function automatic int unsigned tw_index(input int unsigned j, input int unsigned s,
                                           input int unsigned n);
    int unsigned mask;
    mask = (32'd1 << s) - 32'd1;
    return (j & mask) << (n - 1 - s);
  endfunction

endpackage

// File: rtl/fft_bfp_accumulator.sv
// Block-floating-point bookkeeping applied once per FFT stage.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   clear         : zero ibfp and the exponent (new transform accepted)
//   update        : capture width and accumulate its scaling shift
//   width         : post-stage max bit width from the butterfly detector
//   ibfp          : bit width applied to the current stage
//   bfp_exponent  : saturating sum of per-stage shifts
module fft_bfp_accumulator
  import fft_pkg::*;
#(
  parameter int unsigned FFT_DW            = 16,
  parameter int unsigned FFT_MAX_BIT_WIDTH = 5,
  parameter int unsigned EXP_W             = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         update,
  input  logic [FFT_MAX_BIT_WIDTH-1:0] width,
  output logic [FFT_MAX_BIT_WIDTH-1:0] ibfp,
  output logic [EXP_W-1:0]             bfp_exponent
);

  localparam logic [31:0] HEADROOM = 32'(FFT_DW - 2);
  localparam logic [31:0] EXP_MAX  = 32'((64'd1 << EXP_W) - 64'd1);

  logic [FFT_MAX_BIT_WIDTH-1:0] ibfp_q;
  logic [EXP_W-1:0]             exp_q, exp_d;
  logic [31:0]                  w_ext, shift, sum;

  // Anything above FFT_DW-2 bits must be shifted out before the next stage can grow.
  always_comb begin
    w_ext = 32'(width);
    shift = (w_ext > HEADROOM) ? (w_ext - HEADROOM) : 32'd0;
    sum   = 32'(exp_q) + shift;
    exp_d = (sum > EXP_MAX) ? EXP_W'(EXP_MAX) : EXP_W'(sum);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ibfp_q <= '0;
      exp_q  <= '0;
    end else if (clear) begin
      ibfp_q <= '0;
      exp_q  <= '0;
    end else if (update) begin
      ibfp_q <= width;
      exp_q  <= exp_d;
    end
  end

  assign ibfp         = ibfp_q;
  assign bfp_exponent = exp_q;

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for an in-place radix-2 FFT: issues one butterfly per cycle for every
// stage, waits for the butterfly core to drain, then updates block-floating-point state.
// Build option: define FFT_SEQ_WATCHDOG_EN to enable the DRAIN watchdog (error output).
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   start                          : begin a transform (sampled only in idle)
//   busy, done                     : activity flag, one-cycle end-of-transform pulse
//   iact, ictrl                    : butterfly issue strobe and last-of-stage/last-of-fft
//   input_memory_address           : butterfly index j
//   twiddle_addr                   : twiddle ROM index
//   stage                          : current stage s
//   bank_sel                       : ping-pong read bank (write bank is ~bank_sel)
//   clr_bfp                        : one-cycle clear for downstream BFP tracking
//   ibfp, bfp_exponent             : stage bit width and accumulated scaling
//   bt_oact, bt_octrl              : butterfly core output strobe/control
//   max_bit_width_after_butterfly  : detector result for the stage just drained
//   error                          : sticky drain watchdog flag
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned FFT_N             = 10,
  parameter int unsigned FFT_DW            = 16,
  parameter int unsigned FFT_MAX_BIT_WIDTH = 5,
  parameter int unsigned EXP_W             = 6,
  parameter int unsigned DRAIN_TIMEOUT     = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           iact,
  output logic [1:0]                     ictrl,
  output logic [FFT_N-2:0]               input_memory_address,
  output logic [FFT_N-2:0]               twiddle_addr,
  output logic [stage_w(FFT_N)-1:0]      stage,
  output logic                           bank_sel,
  output logic                           clr_bfp,
  output logic [FFT_MAX_BIT_WIDTH-1:0]   ibfp,
  output logic [EXP_W-1:0]               bfp_exponent,
  input  logic                           bt_oact,
  input  logic [1:0]                     bt_octrl,
  input  logic [FFT_MAX_BIT_WIDTH-1:0]   max_bit_width_after_butterfly,
  output logic                           error
);

  localparam int unsigned          STAGE_W = stage_w(FFT_N);
  localparam int unsigned          J_W     = FFT_N - 1;
  localparam logic [J_W-1:0]       J_LAST  = '1;
  localparam logic [STAGE_W-1:0]   S_LAST  = STAGE_W'(FFT_N - 1);

  state_e             state_q, state_d;
  logic [J_W-1:0]     j_q, j_d, tw_q, tw_d;
  logic [STAGE_W-1:0] s_q, s_d;
  logic               bank_q, bank_d;
  logic               iact_q, busy_q, done_q, clr_q, clr_d;
  logic [1:0]         ictrl_q, ictrl_d;
  logic               accept, do_update, timeout, issue_d, last_d;

  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    s_d       = s_q;
    bank_d    = bank_q;
    clr_d     = 1'b0;
    accept    = 1'b0;
    do_update = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          j_d     = '0;
          s_d     = '0;
          bank_d  = 1'b0;
          clr_d   = 1'b1;
          accept  = 1'b1;
        end
      end
      StIssue: begin
        if (j_q == J_LAST) state_d = StDrain;
        else               j_d     = j_q + 1'b1;
      end
      StDrain: begin
        // The core's last-of-stage marker is the only proof the pipeline is empty.
        if (bt_oact && bt_octrl[CTRL_LAST_STAGE]) state_d = StUpdate;
        else if (timeout)                         state_d = StDone;
      end
      StUpdate: begin
        do_update = 1'b1;
        bank_d    = ~bank_q;
        clr_d     = 1'b1;
        if (s_q == S_LAST) begin
          state_d = StDone;
        end else begin
          state_d = StIssue;
          s_d     = s_q + 1'b1;
          j_d     = '0;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_comb begin
    issue_d                  = (state_d == StIssue);
    last_d                   = issue_d && (j_d == J_LAST);
    ictrl_d                  = '0;
    ictrl_d[CTRL_LAST_STAGE] = last_d;
    ictrl_d[CTRL_LAST_FFT]   = last_d && (s_d == S_LAST);
    tw_d                     = issue_d ? J_W'(tw_index(32'(j_d), 32'(s_d), FFT_N)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      j_q     <= '0;
      s_q     <= '0;
      bank_q  <= 1'b0;
      tw_q    <= '0;
      ictrl_q <= '0;
      iact_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      s_q     <= s_d;
      bank_q  <= bank_d;
      tw_q    <= tw_d;
      ictrl_q <= ictrl_d;
      iact_q  <= issue_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StDone);
      clr_q   <= clr_d;
    end
  end

`ifdef FFT_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(DRAIN_TIMEOUT + 1);

  logic [WD_W-1:0] wd_q;
  logic            error_q;

  // wd_q counts DRAIN cycles already spent; the DRAIN_TIMEOUT-th cycle gives up.
  assign timeout = (state_q == StDrain) && (32'(wd_q) + 32'd1 >= DRAIN_TIMEOUT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q <= (state_q == StDrain) ? wd_q + 1'b1 : '0;
      if (accept)                                         error_q <= 1'b0;
      else if (state_q == StDrain && state_d == StDone)   error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{bt_octrl[CTRL_LAST_FFT], 32'(DRAIN_TIMEOUT)};

  fft_bfp_accumulator #(
    .FFT_DW            (FFT_DW),
    .FFT_MAX_BIT_WIDTH (FFT_MAX_BIT_WIDTH),
    .EXP_W             (EXP_W)
  ) u_bfp (
    .clk          (clk),
    .reset        (reset),
    .clear        (accept),
    .update       (do_update),
    .width        (max_bit_width_after_butterfly),
    .ibfp         (ibfp),
    .bfp_exponent (bfp_exponent)
  );

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign iact                 = iact_q;
  assign ictrl                = ictrl_q;
  assign input_memory_address = j_q;
  assign twiddle_addr         = tw_q;
  assign stage                = s_q;
  assign bank_sel             = bank_q;
  assign clr_bfp              = clr_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer (FFT_N=3). A second instance with EXP_W=2
// shares all stimulus to observe exponent saturation. Expected butterfly beats and
// end-of-transform results are queued when a transform is launched and popped by a
// monitor as the DUT produces them. Watchdog checks run when FFT_SEQ_WATCHDOG_EN is set.
module tb_fft_stage_sequencer;

  localparam int N    = 3;
  localparam int HALF = 4;
  localparam int DW   = 16;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       busy, done, iact, clr_bfp, bank_sel, error;
  logic [1:0] ictrl, addr, tw, stage;
  logic [4:0] ibfp;
  logic [5:0] expo;
  logic       s_busy, s_done, s_iact, s_clr, s_bank, s_error;
  logic [1:0] s_ictrl, s_addr, s_tw, s_stage, s_expo;
  logic [4:0] s_ibfp;
  logic       bt_oact;
  logic [1:0] bt_octrl;
  logic [4:0] max_bw;

  logic       det_mode, mute, spur_act, mon_en;
  logic [1:0] spur_ctrl;
  logic [3:0] pv;
  logic [7:0] pc;
  logic       done_prev;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0] addr, tw, ictrl, stage;
    logic       bank, clr;
    logic [4:0] ibfp;
    logic [5:0] expo;
    logic [1:0] exps;
  } beat_t;

  typedef struct packed {
    logic [5:0] expo;
    logic [4:0] ibfp;
    logic       bank;
    logic [1:0] exps;
  } res_t;

  beat_t beat_q[$];
  res_t  res_q[$];
  beat_t mb;
  res_t  mr;

  always #5 clk = ~clk;

`ifdef FFT_SEQ_WATCHDOG_EN
  localparam int TIMEOUT = 8;
`else
  localparam int TIMEOUT = 64;
`endif

  fft_stage_sequencer #(
    .FFT_N(N), .FFT_DW(DW), .FFT_MAX_BIT_WIDTH(5), .EXP_W(6), .DRAIN_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .iact(iact),
    .ictrl(ictrl), .input_memory_address(addr), .twiddle_addr(tw), .stage(stage),
    .bank_sel(bank_sel), .clr_bfp(clr_bfp), .ibfp(ibfp), .bfp_exponent(expo),
    .bt_oact(bt_oact), .bt_octrl(bt_octrl), .max_bit_width_after_butterfly(max_bw),
    .error(error)
  );

  fft_stage_sequencer #(
    .FFT_N(N), .FFT_DW(DW), .FFT_MAX_BIT_WIDTH(5), .EXP_W(2), .DRAIN_TIMEOUT(TIMEOUT)
  ) dut_sat (
    .clk(clk), .reset(reset), .start(start), .busy(s_busy), .done(s_done), .iact(s_iact),
    .ictrl(s_ictrl), .input_memory_address(s_addr), .twiddle_addr(s_tw), .stage(s_stage),
    .bank_sel(s_bank), .clr_bfp(s_clr), .ibfp(s_ibfp), .bfp_exponent(s_expo),
    .bt_oact(bt_oact), .bt_octrl(bt_octrl), .max_bit_width_after_butterfly(max_bw),
    .error(s_error)
  );

  // Butterfly core model: fixed 4-cycle latency, reset together with the sequencer.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      pc <= '0;
    end else begin
      pv <= {pv[2:0], iact & ~mute};
      pc <= {pc[5:0], ictrl};
    end
  end

  assign bt_oact  = pv[3] | spur_act;
  assign bt_octrl = spur_act ? spur_ctrl : (pv[3] ? pc[7:6] : 2'b00);
  // Detector: 14+stage normally, constant 16 in mode 1.
  assign max_bw   = det_mode ? 5'd16 : 5'(14 + int'(stage));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_run(input bit mode);
    int e, es, w, sh, ib;
    beat_t b;
    res_t  r;
    e = 0; es = 0; ib = 0;
    for (int s = 0; s < N; s++) begin
      for (int j = 0; j < HALF; j++) begin
        b.addr     = 2'(j);
        b.tw       = 2'((j % (1 << s)) << (N - 1 - s));
        b.ictrl[0] = (j == HALF - 1);
        b.ictrl[1] = (j == HALF - 1) && (s == N - 1);
        b.stage    = 2'(s);
        b.bank     = 1'(s % 2);
        b.clr      = (j == 0);
        b.ibfp     = 5'(ib);
        b.expo     = 6'(e);
        b.exps     = 2'(es);
        beat_q.push_back(b);
      end
      w  = mode ? 16 : 14 + s;
      ib = w;
      sh = (w > DW - 2) ? w - (DW - 2) : 0;
      e  = (e + sh > 63) ? 63 : e + sh;
      es = (es + sh > 3) ? 3 : es + sh;
    end
    r.expo = 6'(e);
    r.ibfp = 5'(ib);
    r.bank = 1'(N % 2);
    r.exps = 2'(es);
    res_q.push_back(r);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_idle(input string p);
    check({p, "_busy"}, 32'(busy), 0);
    check({p, "_done"}, 32'(done), 0);
    check({p, "_iact"}, 32'(iact), 0);
    check({p, "_ictrl"}, 32'(ictrl), 0);
    check({p, "_addr"}, 32'(addr), 0);
    check({p, "_tw"}, 32'(tw), 0);
    check({p, "_stage"}, 32'(stage), 0);
    check({p, "_bank"}, 32'(bank_sel), 0);
    check({p, "_clr"}, 32'(clr_bfp), 0);
    check({p, "_ibfp"}, 32'(ibfp), 0);
    check({p, "_exp"}, 32'(expo), 0);
    check({p, "_error"}, 32'(error), 0);
  endtask

  // Monitor: compares every issued beat and every done pulse against the queues.
  always @(negedge clk) begin
    if (!reset && mon_en) begin
      if (iact) begin
        if (beat_q.size() == 0) begin
          check("iact_unexpected", 32'(iact), 0);
        end else begin
          mb = beat_q.pop_front();
          check("beat_addr", 32'(addr), 32'(mb.addr));
          check("beat_tw", 32'(tw), 32'(mb.tw));
          check("beat_ictrl", 32'(ictrl), 32'(mb.ictrl));
          check("beat_stage", 32'(stage), 32'(mb.stage));
          check("beat_bank", 32'(bank_sel), 32'(mb.bank));
          check("beat_clr", 32'(clr_bfp), 32'(mb.clr));
          check("beat_ibfp", 32'(ibfp), 32'(mb.ibfp));
          check("beat_exp", 32'(expo), 32'(mb.expo));
          check("beat_exp_sat", 32'(s_expo), 32'(mb.exps));
          check("beat_busy", 32'(busy), 1);
        end
      end
      if (done) begin
        check("done_len", 32'(done_prev), 0);
        if (res_q.size() == 0) begin
          check("done_unexpected", 32'(done), 0);
        end else begin
          mr = res_q.pop_front();
          check("res_exp", 32'(expo), 32'(mr.expo));
          check("res_ibfp", 32'(ibfp), 32'(mr.ibfp));
          check("res_bank", 32'(bank_sel), 32'(mr.bank));
          check("res_exp_sat", 32'(s_expo), 32'(mr.exps));
          check("res_clr", 32'(clr_bfp), 1);
          check("res_iact", 32'(iact), 0);
        end
      end
    end
    done_prev <= done;
  end

  initial begin
    bit ok;
    int cyc;
    reset = 1'b1; start = 1'b0; det_mode = 1'b0; mute = 1'b0;
    spur_act = 1'b0; spur_ctrl = 2'b00; mon_en = 1'b0;
    repeat (3) tick();
    check_idle("rst_held");
    reset = 1'b0;
    tick();
    check_idle("rst");

    // Run A: widths 14,15,16 -> exponent 0,1,3.
    det_mode = 1'b0;
    mon_en   = 1'b1;
    push_run(1'b0);
    pulse_start();
    wait_done(200, ok);
    check("a_done_seen", 32'(ok), 1);
    tick();
    check("a_busy_after", 32'(busy), 0);
    check("a_done_after", 32'(done), 0);
    check("a_bank_hold", 32'(bank_sel), 1);
    check("a_exp_hold", 32'(expo), 3);
    check("a_beats_left", 32'(beat_q.size()), 0);

    // Run B: constant 16, start pulses while busy, spurious core strobe during ISSUE.
    det_mode = 1'b1;
    push_run(1'b1);
    pulse_start();
    pulse_start();
    cyc = 0;
    while (iact && cyc < 50) begin
      tick();
      cyc++;
    end
    check("b_drain_reached", 32'(iact == 1'b0 && busy == 1'b1), 1);
    pulse_start();
    cyc = 0;
    while (!(iact && stage == 2'd1) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("b_stage1_reached", 32'(iact && stage == 2'd1), 1);
    spur_act  = 1'b1;
    spur_ctrl = 2'b01;
    tick();
    spur_act  = 1'b0;
    spur_ctrl = 2'b00;
    wait_done(200, ok);
    check("b_done_seen", 32'(ok), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b_start_in_done_busy", 32'(busy), 0);
    tick();
    check("b_idle_busy", 32'(busy), 0);
    check("b_idle_iact", 32'(iact), 0);
    check("b_beats_left", 32'(beat_q.size()), 0);
    check("b_res_left", 32'(res_q.size()), 0);

    // Reset in the middle of stage 1 ISSUE, then a fresh transform.
    det_mode = 1'b0;
    push_run(1'b0);
    pulse_start();
    cyc = 0;
    while (!(iact && stage == 2'd1 && addr == 2'd1) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("r_stage1_reached", 32'(iact && stage == 2'd1), 1);
    mon_en = 1'b0;
    reset  = 1'b1;
    tick();
    check_idle("midrst");
    reset = 1'b0;
    beat_q.delete();
    res_q.delete();
    tick();
    push_run(1'b0);
    mon_en = 1'b1;
    pulse_start();
    wait_done(200, ok);
    check("r_done_seen", 32'(ok), 1);
    tick();
    check("r_beats_left", 32'(beat_q.size()), 0);

`ifdef FFT_SEQ_WATCHDOG_EN
    // Core never reports the end of stage: watchdog must end the transform.
    mon_en = 1'b0;
    mute   = 1'b1;
    pulse_start();
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy && !iact) cyc++;
      tick();
    end
    check("wd_done_seen", 32'(ok), 1);
    check("wd_drain_len_ok", 32'(cyc >= 1 && cyc <= TIMEOUT), 1);
    check("wd_error_set", 32'(error), 1);
    tick();
    check("wd_idle_busy", 32'(busy), 0);
    check("wd_error_sticky", 32'(error), 1);
    mute = 1'b0;
    pulse_start();
    check("wd_error_cleared", 32'(error), 0);
    wait_done(200, ok);
    check("wd_clean_done", 32'(ok), 1);
    check("wd_clean_error", 32'(error), 0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
